// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - master/slave bundle between two requesters, the arbiter and mem_controller
`timescale 1ns/1ps
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [3:0]        m0_be_n;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_err;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [3:0]        m1_be_n;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_err;

    logic              s_oen;
    logic              s_wen;
    logic [3:0]        s_be_n;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [DATA_W-1:0] s_rdata;
    logic              s_done;
    logic [1:0]        grant;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_be_n, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_be_n, m1_wdata,
        input  s_rdata, s_done,
        output m0_ack, m0_rdata, m0_err,
        output m1_ack, m1_rdata, m1_err,
        output s_oen, s_wen, s_be_n, s_addr, s_wdata, grant
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_be_n, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_be_n, m1_wdata,
        output s_rdata, s_done,
        input  m0_ack, m0_rdata, m0_err,
        input  m1_ack, m1_rdata, m1_err,
        input  s_oen, s_wen, s_be_n, s_addr, s_wdata, grant
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sharing of the mem_controller port by two masters; ARB_TIMEOUT_EN adds an access timeout
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input logic               clk_40M,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RELEASE = 2'd2} state_t;

    state_t            state_q, state_nxt;
    logic              last_q, last_nxt;
    logic              owner_q, owner_nxt;
    logic              oen_q, oen_nxt;
    logic              wen_q, wen_nxt;
    logic [3:0]        be_q, be_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt;
    logic [1:0]        grant_q, grant_nxt;
    logic [1:0]        ack_q, ack_nxt;
    logic [1:0]        err_q, err_nxt;
    logic [DATA_W-1:0] rdata0_q, rdata0_nxt;
    logic [DATA_W-1:0] rdata1_q, rdata1_nxt;
    logic              finish, timed_out;
    logic [DATA_W-1:0] rd_val;
`ifdef ARB_TIMEOUT_EN
    logic [31:0]       cnt_q, cnt_nxt;
`endif

    logic              any_req, sel, sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [3:0]        sel_be_n;
    logic [DATA_W-1:0] sel_wdata;

    // On a tie the master that did not win last time is chosen
    assign any_req   = bus.m0_req | bus.m1_req;
    assign sel       = (bus.m0_req & bus.m1_req) ? ~last_q : bus.m1_req;
    assign sel_we    = sel ? bus.m1_we    : bus.m0_we;
    assign sel_addr  = sel ? bus.m1_addr  : bus.m0_addr;
    assign sel_be_n  = sel ? bus.m1_be_n  : bus.m0_be_n;
    assign sel_wdata = sel ? bus.m1_wdata : bus.m0_wdata;

    always_comb begin
        state_nxt  = state_q;
        last_nxt   = last_q;
        owner_nxt  = owner_q;
        oen_nxt    = oen_q;
        wen_nxt    = wen_q;
        be_nxt     = be_q;
        addr_nxt   = addr_q;
        wdata_nxt  = wdata_q;
        grant_nxt  = grant_q;
        ack_nxt    = 2'b00;
        err_nxt    = 2'b00;
        rdata0_nxt = rdata0_q;
        rdata1_nxt = rdata1_q;
        finish     = 1'b0;
        timed_out  = 1'b0;
        rd_val     = bus.s_rdata;
`ifdef ARB_TIMEOUT_EN
        cnt_nxt    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_nxt = sel;
                    grant_nxt = sel ? 2'b10 : 2'b01;
                    addr_nxt  = sel_addr;
                    be_nxt    = sel_be_n;
                    wdata_nxt = sel_wdata;
                    oen_nxt   = sel_we;
                    wen_nxt   = ~sel_we;
`ifdef ARB_TIMEOUT_EN
                    cnt_nxt   = 32'd0;
`endif
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                finish = bus.s_done;
`ifdef ARB_TIMEOUT_EN
                timed_out = !bus.s_done && (cnt_q == 32'(TIMEOUT - 1));
                cnt_nxt   = cnt_q + 32'd1;
`endif
                if (finish || timed_out) begin
                    oen_nxt   = 1'b1;
                    wen_nxt   = 1'b1;
                    ack_nxt   = owner_q ? 2'b10 : 2'b01;
                    err_nxt   = timed_out ? ack_nxt : 2'b00;
                    rd_val    = timed_out ? {DATA_W{1'b0}} : bus.s_rdata;
                    // Writes keep the owner's previous read data
                    if (timed_out || !oen_q) begin
                        if (owner_q) rdata1_nxt = rd_val;
                        else         rdata0_nxt = rd_val;
                    end
                    last_nxt  = owner_q;
                    grant_nxt = 2'b00;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_40M or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            oen_q    <= 1'b1;
            wen_q    <= 1'b1;
            be_q     <= 4'b0000;
            addr_q   <= '0;
            wdata_q  <= '0;
            grant_q  <= 2'b00;
            ack_q    <= 2'b00;
            err_q    <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= 32'd0;
`endif
        end else begin
            state_q  <= state_nxt;
            last_q   <= last_nxt;
            owner_q  <= owner_nxt;
            oen_q    <= oen_nxt;
            wen_q    <= wen_nxt;
            be_q     <= be_nxt;
            addr_q   <= addr_nxt;
            wdata_q  <= wdata_nxt;
            grant_q  <= grant_nxt;
            ack_q    <= ack_nxt;
            err_q    <= err_nxt;
            rdata0_q <= rdata0_nxt;
            rdata1_q <= rdata1_nxt;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= cnt_nxt;
`endif
        end
    end

    assign bus.s_oen    = oen_q;
    assign bus.s_wen    = wen_q;
    assign bus.s_be_n   = be_q;
    assign bus.s_addr   = addr_q;
    assign bus.s_wdata  = wdata_q;
    assign bus.grant    = grant_q;
    assign bus.m0_ack   = ack_q[0];
    assign bus.m1_ack   = ack_q[1];
    assign bus.m0_err   = err_q[0];
    assign bus.m1_err   = err_q[1];
    assign bus.m0_rdata = rdata0_q;
    assign bus.m1_rdata = rdata1_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter against a transaction-level model
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk_40M = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] ta [2];
    logic [31:0] tw [2];
    logic [3:0]  tbe [2];
    logic        twe [2];
    logic [31:0] exp_rd [2];
    bit          pend [2];
    bit          req_s [2];
    int          rem [2];
    int          last_own, owner, ack_due, lat, cyc, last_ack_cyc, g;
    logic [31:0] rd_ret;
    logic [1:0]  exp_g;

    always #12 clk_40M = ~clk_40M;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW)
`ifdef ARB_TIMEOUT_EN
        , .TIMEOUT(8)
`endif
    ) dut (
        .clk_40M(clk_40M),
        .rst    (rst),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_40M);
        @(negedge clk_40M);
    endtask

    task automatic drive_master(input int m);
        if (m == 0) begin
            bus.m0_req = req_s[0]; bus.m0_we = twe[0]; bus.m0_addr = ta[0];
            bus.m0_be_n = tbe[0]; bus.m0_wdata = tw[0];
        end else begin
            bus.m1_req = req_s[1]; bus.m1_we = twe[1]; bus.m1_addr = ta[1];
            bus.m1_be_n = tbe[1]; bus.m1_wdata = tw[1];
        end
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            ta[m] = '0; tw[m] = '0; tbe[m] = '0; twe[m] = 1'b0; req_s[m] = 1'b0;
            drive_master(m);
        end
        bus.s_done = 1'b0; bus.s_rdata = '0;
        repeat (2) @(negedge clk_40M);
        chk("reset_ctl", 64'({bus.s_oen, bus.s_wen, bus.grant, bus.s_be_n, bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err}), 64'(12'b1100_0000_0000));
        chk("reset_data", 64'({bus.s_addr, bus.s_wdata}), 64'd0);
        chk("reset_rdata", 64'({bus.m0_rdata, bus.m1_rdata}), 64'd0);
        rst = 1'b0;

        // Single read by m0, done after three strobe cycles
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h8000_0000; bus.m0_be_n = 4'b0000;
        tick();
        chk("rd_strobe", 64'({bus.s_oen, bus.s_wen, bus.grant}), 64'(4'b0101));
        chk("rd_addr", 64'(bus.s_addr), 64'h8000_0000);
        chk("rd_be", 64'(bus.s_be_n), 64'd0);
        tick();
        chk("rd_hold1", 64'({bus.s_oen, bus.s_wen, bus.grant, bus.m0_ack}), 64'(5'b01010));
        tick();
        chk("rd_hold2", 64'({bus.s_oen, bus.s_wen, bus.grant, bus.m0_ack}), 64'(5'b01010));
        bus.s_done = 1'b1; bus.s_rdata = 32'h1234_5678;
        tick();
        chk("rd_ack", 64'({bus.m0_ack, bus.m1_ack, bus.s_oen, bus.s_wen, bus.grant}), 64'(6'b101100));
        chk("rd_data", 64'(bus.m0_rdata), 64'h1234_5678);

        // Stray done in RELEASE and IDLE
        bus.m0_req = 1'b0; bus.s_rdata = 32'hDEAD_BEEF;
        tick();
        chk("stray_rel", 64'({bus.m0_ack, bus.m1_ack, bus.grant, bus.s_oen, bus.s_wen}), 64'(6'b000011));
        tick();
        chk("stray_idle", 64'({bus.m0_ack, bus.m1_ack, bus.grant, bus.s_oen, bus.s_wen}), 64'(6'b000011));
        chk("stray_rdata", 64'(bus.m0_rdata), 64'h1234_5678);
        bus.s_done = 1'b0;

        // Single write by m1
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h8040_0004;
        bus.m1_be_n = 4'b1110; bus.m1_wdata = 32'hAABB_CCDD;
        tick();
        chk("wr_strobe", 64'({bus.s_oen, bus.s_wen, bus.grant}), 64'(4'b1010));
        chk("wr_bus", 64'({bus.s_be_n, bus.s_wdata}), 64'({4'b1110, 32'hAABB_CCDD}));
        chk("wr_addr", 64'(bus.s_addr), 64'h8040_0004);
        bus.s_done = 1'b1; bus.s_rdata = 32'h5555_5555;
        tick();
        chk("wr_ack", 64'({bus.m0_ack, bus.m1_ack, bus.s_oen, bus.s_wen, bus.grant}), 64'(6'b011100));
        chk("wr_rdata", 64'({bus.m1_rdata, bus.m0_rdata}), 64'({32'h0, 32'h1234_5678}));
        bus.m1_req = 1'b0; bus.s_done = 1'b0;
        tick();
        chk("wr_ack_once", 64'(bus.m1_ack), 64'd0);
        tick();

        // Contention: last winner was m1, so m0 leads and the two alternate
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.s_done = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_g = (i % 3 == 0) ? (((i / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            chk($sformatf("cont_grant%0d", i), 64'(bus.grant), 64'(exp_g));
            exp_g = (i % 3 == 1) ? (((i / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            chk($sformatf("cont_ack%0d", i), 64'({bus.m1_ack, bus.m0_ack}), 64'(exp_g));
        end
        bus.m0_req = 1'b0; bus.m1_req = 1'b0; bus.s_done = 1'b0;
        tick();

        // Reset in the middle of an m1 access
        bus.m1_req = 1'b1; bus.m1_we = 1'b0;
        tick();
        chk("mid_grant", 64'(bus.grant), 64'(2'b10));
        #3 rst = 1'b1;
        #1 chk("mid_rst", 64'({bus.s_oen, bus.s_wen, bus.grant, bus.m0_ack, bus.m1_ack}), 64'(6'b110000));
        @(negedge clk_40M);
        rst = 1'b0;
        tick();
        chk("post_rst_m1", 64'(bus.grant), 64'(2'b10));
        bus.s_done = 1'b1; bus.s_rdata = 32'h0BAD_F00D;
        tick();
        chk("post_rst_ack", 64'({bus.m1_ack, bus.m1_rdata}), 64'({1'b1, 32'h0BAD_F00D}));
        bus.m1_req = 1'b0; bus.s_done = 1'b0;
        tick();
        tick();
        bus.m0_req = 1'b1; bus.m1_req = 1'b1; rst = 1'b1;
        @(negedge clk_40M);
        rst = 1'b0;
        tick();
        chk("rst_tie", 64'(bus.grant), 64'(2'b01));
        rst = 1'b1; bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        @(negedge clk_40M);
        rst = 1'b0;

`ifdef ARB_TIMEOUT_EN
        bus.m0_req = 1'b1; bus.m0_we = 1'b0;
        tick();
        chk("to_grant", 64'(bus.grant), 64'(2'b01));
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("to_wait%0d", i), 64'(bus.m0_ack), 64'd0);
        end
        tick();
        chk("to_ack", 64'({bus.m0_ack, bus.m0_err, bus.m0_rdata, bus.s_oen}), 64'({2'b11, 32'h0, 1'b1}));
        bus.m0_req = 1'b0; bus.s_done = 1'b1;
        tick();
        chk("to_stray", 64'({bus.m0_ack, bus.m0_err}), 64'd0);
        bus.s_done = 1'b0;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0;
        tick();
        bus.s_done = 1'b1; bus.s_rdata = 32'hCAFE_0001;
        tick();
        chk("to_next", 64'({bus.m1_ack, bus.m1_err, bus.m1_rdata}), 64'({2'b10, 32'hCAFE_0001}));
        bus.m1_req = 1'b0; bus.s_done = 1'b0;
        rst = 1'b1;
        @(negedge clk_40M);
        rst = 1'b0;
`endif

        // Randomized traffic against a transaction-level model
        rem[0] = 20; rem[1] = 20; pend[0] = 0; pend[1] = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        last_own = 1; owner = -1; ack_due = -1; cyc = 0; last_ack_cyc = -10; lat = 0; rd_ret = '0;
        while ((rem[0] + rem[1] + int'(pend[0]) + int'(pend[1])) > 0 && cyc < 4000) begin
            bus.s_done = 1'b0; bus.s_rdata = $urandom;
            if (owner >= 0) begin
                if (lat == 0) begin bus.s_done = 1'b1; rd_ret = bus.s_rdata; ack_due = owner; end
                else lat--;
            end else begin
                bus.s_done = ($urandom_range(0, 3) == 0);
            end
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && rem[m] > 0 && $urandom_range(0, 2) == 0) begin
                    pend[m] = 1; rem[m]--;
                    ta[m] = $urandom; tw[m] = $urandom; tbe[m] = 4'($urandom); twe[m] = 1'($urandom);
                end
                req_s[m] = pend[m];
                drive_master(m);
            end
            tick();
            cyc++;
            exp_g = (ack_due == 0) ? 2'b01 : (ack_due == 1) ? 2'b10 : 2'b00;
            chk("rnd_ack", 64'({bus.m1_ack, bus.m0_ack}), 64'(exp_g));
            if (ack_due >= 0) begin
                if (!twe[ack_due]) exp_rd[ack_due] = rd_ret;
                chk("rnd_err", 64'({bus.m1_err, bus.m0_err}), 64'd0);
                pend[ack_due] = 0; last_own = ack_due; owner = -1; last_ack_cyc = cyc; ack_due = -1;
            end
            chk("rnd_rdata", 64'({bus.m1_rdata, bus.m0_rdata}), 64'({exp_rd[1], exp_rd[0]}));
            if (owner < 0 && (req_s[0] || req_s[1]) && cyc >= last_ack_cyc + 2) begin
                g = (req_s[0] && req_s[1]) ? 1 - last_own : (req_s[0] ? 0 : 1);
                owner = g; lat = $urandom_range(0, 4);
                chk("rnd_addr", 64'(bus.s_addr), 64'(ta[g]));
                chk("rnd_strobe", 64'({bus.s_oen, bus.s_wen, bus.s_be_n}), 64'({twe[g], ~twe[g], tbe[g]}));
                if (twe[g]) chk("rnd_wdata", 64'(bus.s_wdata), 64'(tw[g]));
            end
            exp_g = (owner < 0) ? 2'b00 : (owner == 0) ? 2'b01 : 2'b10;
            chk("rnd_grant", 64'(bus.grant), 64'(exp_g));
        end
        chk("rnd_complete", 64'(rem[0] + rem[1] + int'(pend[0]) + int'(pend[1])), 64'd0);
        chk("rnd_budget", 64'(cyc < 4000), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
